// File: rtl/mc_bus_arb_if.sv
// Bus request/grant bundle between the memory-controller arbiter and the external requesters.
interface mc_bus_arb_if #(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] mc_br_pad_i;
  logic             mc_busy_i;
  logic [N_REQ-1:0] mc_bg_pad_o;
  logic             mc_pad_oe_o;
  logic             mc_own_o;
  logic [IDW-1:0]   mc_grant_id_o;
  logic             mc_preempt_o;

  modport master (
    input  mc_br_pad_i, mc_busy_i,
    output mc_bg_pad_o, mc_pad_oe_o, mc_own_o, mc_grant_id_o, mc_preempt_o
  );

  modport slave (
    output mc_br_pad_i, mc_busy_i,
    input  mc_bg_pad_o, mc_pad_oe_o, mc_own_o, mc_grant_id_o, mc_preempt_o
  );
endinterface

// File: rtl/mc_bus_arb.sv
// External bus arbiter: the controller owns the bus by default and hands it to one
// requester at a time through turnaround gaps, with round-robin fairness and optional hold limit.
module mc_bus_arb #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned IDLE_GAP = 1,
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic         mc_clk_i,
  input  logic         mc_rst_n_i,
  mc_bus_arb_if.master bus
);
  localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned GW  = $clog2(IDLE_GAP + 1);
  localparam int unsigned HW  = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

  typedef enum logic [1:0] {OWN, TURN_OUT, GRANT, TURN_IN} state_t;

  state_t           state;
  logic             run;
  logic [N_REQ-1:0] bg_q;
  logic             pad_oe_q;
  logic             own_q;
  logic             preempt_q;
  logic [IDW-1:0]   grant_id_q;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   winner;
  logic [GW-1:0]    gap_cnt;
  logic [HW-1:0]    hold_cnt;

  logic [IDW-1:0]   winner_c;
  logic             br_win_c;
  logic             hold_done_c;

  // Round-robin search starting one past the last granted requester.
  function automatic logic [IDW-1:0] rr_next(input logic [N_REQ-1:0] req,
                                             input logic [IDW-1:0]   ptr);
    logic [IDW-1:0] pick;
    logic [IDW-1:0] idx;
    logic           found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = IDW'((32'(ptr) + i) % N_REQ);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign winner_c    = rr_next(bus.mc_br_pad_i, rr_ptr);
  assign br_win_c    = bus.mc_br_pad_i[winner];
  assign hold_done_c = (HOLD_MAX != 0) && (hold_cnt == HW'(HOLD_MAX));

  // run rises one edge after reset release, so arbitration starts on the second edge.
  always_ff @(posedge mc_clk_i or negedge mc_rst_n_i) begin
    if (!mc_rst_n_i) begin
      state      <= OWN;
      run        <= 1'b0;
      bg_q       <= '0;
      pad_oe_q   <= 1'b1;
      own_q      <= 1'b1;
      preempt_q  <= 1'b0;
      grant_id_q <= '0;
      rr_ptr     <= IDW'(N_REQ - 1);
      winner     <= '0;
      gap_cnt    <= '0;
      hold_cnt   <= '0;
    end else begin
      run       <= 1'b1;
      preempt_q <= 1'b0;
      case (state)
        OWN: begin
          if (run && (|bus.mc_br_pad_i) && !bus.mc_busy_i) begin
            state    <= TURN_OUT;
            winner   <= winner_c;
            pad_oe_q <= 1'b0;
            own_q    <= 1'b0;
            gap_cnt  <= GW'(IDLE_GAP);
          end
        end
        TURN_OUT: begin
          // A withdrawn request aborts the handover without touching rr_ptr.
          if (!br_win_c) begin
            state   <= TURN_IN;
            gap_cnt <= GW'(IDLE_GAP);
          end else if (gap_cnt == GW'(1)) begin
            state      <= GRANT;
            bg_q       <= N_REQ'(1) << winner;
            rr_ptr     <= winner;
            grant_id_q <= winner;
            hold_cnt   <= HW'(1);
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        GRANT: begin
          // A voluntary release on the limit edge takes precedence over preemption.
          if (!br_win_c || hold_done_c) begin
            state     <= TURN_IN;
            bg_q      <= '0;
            gap_cnt   <= GW'(IDLE_GAP);
            preempt_q <= br_win_c;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        TURN_IN: begin
          if (gap_cnt == GW'(1)) begin
            state    <= OWN;
            pad_oe_q <= 1'b1;
            own_q    <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: state <= OWN;
      endcase
    end
  end

  assign bus.mc_bg_pad_o   = bg_q;
  assign bus.mc_pad_oe_o   = pad_oe_q;
  assign bus.mc_own_o      = own_q;
  assign bus.mc_grant_id_o = grant_id_q;
  assign bus.mc_preempt_o  = preempt_q;
endmodule
